// File: rtl/rs_entry_allocator_if.sv
// Dispatch/issue/flush bundle between the RS entry allocator and its neighbours.
// The master side is dispatch, the issue selector and flush; the slave side is the allocator.
interface rs_entry_allocator_if #(
    parameter int QUEUE_DEPTH = 8
);
    localparam int IDX_W = $clog2(QUEUE_DEPTH);

    logic                   dispatch_valid;
    logic                   dispatch_ready;
    logic                   wen;
    logic [IDX_W-1:0]       insert_idx;
    logic                   issue_valid;
    logic [IDX_W-1:0]       issue_idx;
    logic                   clear_en;
    logic [QUEUE_DEPTH-1:0] kill_mask;
    logic [QUEUE_DEPTH-1:0] valid_bits;
    logic [IDX_W:0]         free_count;
    logic                   protocol_err;

    modport master (
        output dispatch_valid,
        output issue_valid,
        output issue_idx,
        output clear_en,
        output kill_mask,
        input  dispatch_ready,
        input  wen,
        input  insert_idx,
        input  valid_bits,
        input  free_count,
        input  protocol_err
    );

    modport slave (
        input  dispatch_valid,
        input  issue_valid,
        input  issue_idx,
        input  clear_en,
        input  kill_mask,
        output dispatch_ready,
        output wen,
        output insert_idx,
        output valid_bits,
        output free_count,
        output protocol_err
    );
endinterface

// File: rtl/rs_entry_allocator.sv
// Reservation-station slot allocator. It tracks slot occupancy, picks a free slot
// round-robin from alloc_ptr, and frees slots on issue grants and on flush kill masks.
module rs_entry_allocator #(
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rs_entry_allocator_if.slave  bus
);
    localparam int IDX_W = $clog2(QUEUE_DEPTH);
    localparam logic [IDX_W:0] DEPTH_CNT = QUEUE_DEPTH[IDX_W:0];

    logic [QUEUE_DEPTH-1:0] r_valid_bits;
    logic [IDX_W-1:0]       r_alloc_ptr;
    logic [IDX_W:0]         r_free_count;
    logic                   r_protocol_err;

    logic                   w_full;
    logic [IDX_W-1:0]       w_sel_idx;
    logic                   w_ready;
    logic                   w_fire;
    logic                   w_issue_bad;
    logic [QUEUE_DEPTH-1:0] w_issue_clr;
    logic [QUEUE_DEPTH-1:0] w_kill_clr;
    logic [QUEUE_DEPTH-1:0] w_alloc_set;
    logic [QUEUE_DEPTH-1:0] w_valid_next;
    logic [IDX_W:0]         w_busy_count;

    // Scan downward from the farthest offset so that the nearest free slot after alloc_ptr wins.
    always_comb begin
        w_full    = 1'b1;
        w_sel_idx = '0;
        for (int k = QUEUE_DEPTH - 1; k >= 0; k--) begin
            if (!r_valid_bits[r_alloc_ptr + IDX_W'(k)]) begin
                w_full    = 1'b0;
                w_sel_idx = r_alloc_ptr + IDX_W'(k);
            end
        end
    end

    assign w_ready     = rst & ~w_full & ~bus.clear_en;
    assign w_fire      = w_ready & bus.dispatch_valid;
    assign w_issue_bad = bus.issue_valid & ~r_valid_bits[bus.issue_idx];

    always_comb begin
        w_issue_clr = '0;
        w_alloc_set = '0;
        if (bus.issue_valid) begin
            w_issue_clr[bus.issue_idx] = 1'b1;
        end
        if (w_fire) begin
            w_alloc_set[w_sel_idx] = 1'b1;
        end
        w_kill_clr   = bus.clear_en ? bus.kill_mask : '0;
        w_valid_next = (r_valid_bits & ~w_issue_clr & ~w_kill_clr) | w_alloc_set;
    end

    always_comb begin
        w_busy_count = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            w_busy_count = w_busy_count + {{IDX_W{1'b0}}, w_valid_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid_bits   <= '0;
            r_alloc_ptr    <= '0;
            r_free_count   <= DEPTH_CNT;
            r_protocol_err <= 1'b0;
        end else begin
            r_valid_bits <= w_valid_next;
            r_free_count <= DEPTH_CNT - w_busy_count;
            if (w_fire) begin
                r_alloc_ptr <= w_sel_idx + 1'b1;
            end
            if (w_issue_bad) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    assign bus.dispatch_ready = w_ready;
    assign bus.wen            = w_fire;
    assign bus.insert_idx     = w_sel_idx;
    assign bus.valid_bits     = r_valid_bits;
    assign bus.free_count     = r_free_count;
    assign bus.protocol_err   = r_protocol_err;
endmodule
